memtype_write_queue: RTL and testbench

Posted-write queue sitting directly downstream of the physical-address memory-type classifier in the memory stage. Accepts translated write requests tagged with `cache_disable` / `write_transparent`, buffers them in order, and dispatches each to the write-back cache port, the uncached Avalon port, or the uncached port followed by a cache-line invalidate. It also exposes an address snoop so the read path can stall on a read-after-write hazard.

---
 rtl/memtype_write_queue.sv | 200 ++++++++++++++++++++
 tb/tb_memtype_write_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memtype_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : memtype_write_queue
//  Description : Posted-write queue behind the memory-type classifier. Buffers
//                translated writes in order and dispatches each to the cache
//                write port, the uncached Avalon port, or the Avalon port
//                followed by a cache-line invalidate. Provides an address
//                snoop for read-after-write hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module memtype_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wr_do,
    output logic        wr_ready,
    input  logic [31:0] wr_address,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_byteenable,
    input  logic        wr_cache_disable,
    input  logic        wr_write_transparent,

    output logic        cachewr_do,
    output logic [29:0] cachewr_address,
    output logic [31:0] cachewr_data,
    output logic [3:0]  cachewr_byteenable,
    input  logic        cachewr_done,

    output logic [29:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,

    output logic        cacheinv_do,
    output logic [27:0] cacheinv_address,
    input  logic        cacheinv_done,

    input  logic [29:0] snoop_address,
    output logic        pending_match,
    output logic        empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CACHE      = 2'd1,
        S_UNCACHED   = 2'd2,
        S_INVALIDATE = 2'd3
    } state_t;

    // Entry storage
    logic [29:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [3:0]         r_be   [DEPTH];
    logic [DEPTH-1:0]   r_cd;
    logic [DEPTH-1:0]   r_wt;
    logic [DEPTH-1:0]   r_valid;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_next;
    logic               r_ready;

    state_t             r_state;
    state_t             w_state_next;

    logic               w_push;
    logic               w_pop;
    logic               w_match;

    // Byte-lane bits of the request address are not stored
    logic               w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^wr_address[1:0];

    // Ready is registered, so a pop never frees a slot for a push in the same cycle
    assign w_push = wr_do & r_ready;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + (c_PTR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - (c_PTR_W+1)'(1);
        end
    end

    // FIFO pointers, occupancy, valid bits and payload storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_valid  <= '0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next != c_FULL);
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_addr[r_wr_ptr]  <= wr_address[31:2];
                r_data[r_wr_ptr]  <= wr_data;
                r_be[r_wr_ptr]    <= wr_byteenable;
                r_cd[r_wr_ptr]    <= wr_cache_disable;
                r_wt[r_wr_ptr]    <= wr_write_transparent;
                r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
            end
        end
    end

    // Dispatch state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dispatch sequencing: route the head, wait for its completion, then pop
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    if (r_cd[r_rd_ptr] || r_wt[r_rd_ptr]) begin
                        w_state_next = S_UNCACHED;
                    end else begin
                        w_state_next = S_CACHE;
                    end
                end
            end
            S_CACHE: begin
                if (cachewr_done) begin
                    w_pop        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_UNCACHED: begin
                if (!avm_waitrequest) begin
                    if (r_wt[r_rd_ptr]) begin
                        w_state_next = S_INVALIDATE;
                    end else begin
                        w_pop        = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_INVALIDATE: begin
                if (cacheinv_done) begin
                    w_pop        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Read-after-write snoop over every valid entry, including the one in flight
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == snoop_address)) begin
                w_match = 1'b1;
            end
        end
    end

    // Port data mirrors the head entry; strobes come from the state register alone
    always_comb begin
        cachewr_do         = (r_state == S_CACHE);
        avm_write          = (r_state == S_UNCACHED);
        cacheinv_do        = (r_state == S_INVALIDATE);
        cachewr_address    = r_addr[r_rd_ptr];
        cachewr_data       = r_data[r_rd_ptr];
        cachewr_byteenable = r_be[r_rd_ptr];
        avm_address        = r_addr[r_rd_ptr];
        avm_writedata      = r_data[r_rd_ptr];
        avm_byteenable     = r_be[r_rd_ptr];
        cacheinv_address   = r_addr[r_rd_ptr][29:2];
        wr_ready           = r_ready;
        pending_match      = w_match;
        empty              = (r_count == '0) && (r_state == S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_memtype_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memtype_write_queue
//  Description : Directed self-checking bench for memtype_write_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memtype_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_do;
    logic        wr_ready;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic [3:0]  wr_byteenable;
    logic        wr_cache_disable;
    logic        wr_write_transparent;
    logic        cachewr_do;
    logic [29:0] cachewr_address;
    logic [31:0] cachewr_data;
    logic [3:0]  cachewr_byteenable;
    logic        cachewr_done;
    logic [29:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        cacheinv_do;
    logic [27:0] cacheinv_address;
    logic        cacheinv_done;
    logic [29:0] snoop_address;
    logic        pending_match;
    logic        empty;

    int n_checks = 0;
    int n_errors = 0;

    memtype_write_queue #(.DEPTH(4)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .wr_do                (wr_do),
        .wr_ready             (wr_ready),
        .wr_address           (wr_address),
        .wr_data              (wr_data),
        .wr_byteenable        (wr_byteenable),
        .wr_cache_disable     (wr_cache_disable),
        .wr_write_transparent (wr_write_transparent),
        .cachewr_do           (cachewr_do),
        .cachewr_address      (cachewr_address),
        .cachewr_data         (cachewr_data),
        .cachewr_byteenable   (cachewr_byteenable),
        .cachewr_done         (cachewr_done),
        .avm_address          (avm_address),
        .avm_write            (avm_write),
        .avm_writedata        (avm_writedata),
        .avm_byteenable       (avm_byteenable),
        .avm_waitrequest      (avm_waitrequest),
        .cacheinv_do          (cacheinv_do),
        .cacheinv_address     (cacheinv_address),
        .cacheinv_done        (cacheinv_done),
        .snoop_address        (snoop_address),
        .pending_match        (pending_match),
        .empty                (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic cd, input logic wt);
        wr_address           = a;
        wr_data              = d;
        wr_byteenable        = be;
        wr_cache_disable     = cd;
        wr_write_transparent = wt;
        wr_do                = 1'b1;
        tick();
        wr_do                = 1'b0;
    endtask

    task automatic wait_cache(input string tag, input logic [29:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        int i = 0;
        while (!cachewr_do && i < 20) begin
            if (avm_write || cacheinv_do) check({tag, "_order"}, 32'd1, 32'd0);
            tick();
            i++;
        end
        check({tag, "_cache_strobe"}, 32'(cachewr_do), 32'd1);
        check({tag, "_cache_addr"}, 32'(cachewr_address), 32'(a));
        check({tag, "_cache_data"}, cachewr_data, d);
        check({tag, "_cache_be"}, 32'(cachewr_byteenable), 32'(be));
        cachewr_done = 1'b1;
        tick();
        cachewr_done = 1'b0;
        check({tag, "_cache_drop"}, 32'(cachewr_do), 32'd0);
    endtask

    task automatic wait_avm(input string tag, input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        int i = 0;
        while (!avm_write && i < 20) begin
            if (cachewr_do || cacheinv_do) check({tag, "_order"}, 32'd1, 32'd0);
            tick();
            i++;
        end
        check({tag, "_avm_strobe"}, 32'(avm_write), 32'd1);
        check({tag, "_avm_addr"}, 32'(avm_address), 32'(a));
        check({tag, "_avm_data"}, avm_writedata, d);
        check({tag, "_avm_be"}, 32'(avm_byteenable), 32'(be));
        tick();
        check({tag, "_avm_drop"}, 32'(avm_write), 32'd0);
    endtask

    task automatic wait_inv(input string tag, input logic [27:0] line);
        int i = 0;
        while (!cacheinv_do && i < 20) begin
            if (cachewr_do || avm_write) check({tag, "_order"}, 32'd1, 32'd0);
            tick();
            i++;
        end
        check({tag, "_inv_strobe"}, 32'(cacheinv_do), 32'd1);
        check({tag, "_inv_addr"}, 32'(cacheinv_address), 32'(line));
        cacheinv_done = 1'b1;
        tick();
        cacheinv_done = 1'b0;
        check({tag, "_inv_drop"}, 32'(cacheinv_do), 32'd0);
    endtask

    task automatic check_idle_after_reset(input string tag);
        check({tag, "_strobes"}, 32'({cachewr_do, avm_write, cacheinv_do}), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_ready"}, 32'(wr_ready), 32'd1);
        check({tag, "_match"}, 32'(pending_match), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                  = 1'b1;
        wr_do                = 1'b0;
        wr_address           = '0;
        wr_data              = '0;
        wr_byteenable        = '0;
        wr_cache_disable     = 1'b0;
        wr_write_transparent = 1'b0;
        cachewr_done         = 1'b0;
        cacheinv_done        = 1'b0;
        avm_waitrequest      = 1'b0;
        snoop_address        = '1;
        tick();
        tick();

        // Reset state
        check_idle_after_reset("reset");
        rst = 1'b0;
        tick();

        // Three mixed-type writes, in order
        push(32'h0000_1000, 32'h1111_1111, 4'hF, 1'b0, 1'b0);
        check("lat_empty_deassert", 32'(empty), 32'd0);
        check("lat_idle_cycle", 32'(cachewr_do), 32'd0);
        push(32'h000A_0004, 32'h2222_2222, 4'h3, 1'b1, 1'b1);
        check("lat_strobe", 32'(cachewr_do), 32'd1);
        push(32'h000B_FFFC, 32'h3333_3333, 4'hC, 1'b1, 1'b0);
        wait_cache("A", 30'h0000_0400, 32'h1111_1111, 4'hF);
        wait_avm("B", 30'h0002_8001, 32'h2222_2222, 4'h3);
        wait_inv("B", 28'h000_A000);
        wait_avm("C", 30'h0002_FFFF, 32'h3333_3333, 4'hC);
        check("t1_empty", 32'(empty), 32'd1);

        // Fill while the Avalon target stalls
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fill%0d_ready", k), 32'(wr_ready), 32'd1);
            push(32'h0010_0000 + 32'(k) * 32'd16, 32'hD000_0000 + 32'(k), 4'(k + 1), 1'b1, 1'b0);
        end
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_head_addr", 32'(avm_address), 32'h0004_0000);

        // Fifth request refused; stray cache completion while uncached is ignored
        wr_address           = 32'h0010_0040;
        wr_data              = 32'hD000_0004;
        wr_byteenable        = 4'h5;
        wr_cache_disable     = 1'b1;
        wr_write_transparent = 1'b0;
        wr_do                = 1'b1;
        cachewr_done         = 1'b1;
        tick();
        cachewr_done = 1'b0;
        check("fifth_ready", 32'(wr_ready), 32'd0);
        check("stray_cdone_strobe", 32'({cachewr_do, avm_write, cacheinv_do}), 32'b010);
        check("stray_cdone_addr", 32'(avm_address), 32'h0004_0000);

        // One-cycle release with a simultaneous (rejected) push
        avm_waitrequest = 1'b0;
        tick();
        wr_do           = 1'b0;
        avm_waitrequest = 1'b1;
        check("ready_after_pop", 32'(wr_ready), 32'd1);

        // One free slot: refill across the pointer wrap
        push(32'h0010_0040, 32'hD000_0004, 4'h5, 1'b1, 1'b0);
        check("refill_full", 32'(wr_ready), 32'd0);
        avm_waitrequest = 1'b0;
        for (int k = 1; k < 5; k++) begin
            wait_avm($sformatf("W%0d", k), 30'h0004_0000 + 30'(k) * 30'd4,
                     32'hD000_0000 + 32'(k), 4'(k + 1));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Snoop
        push(32'h000A_0010, 32'h5555_5555, 4'hF, 1'b0, 1'b0);
        snoop_address = 30'h0002_8004;
        #1;
        check("snoop_hit", 32'(pending_match), 32'd1);
        snoop_address = 30'h0002_8005;
        #1;
        check("snoop_miss", 32'(pending_match), 32'd0);
        snoop_address = 30'h0002_8004;
        tick();
        check("snoop_inflight", 32'(pending_match), 32'd1);
        wait_cache("S", 30'h0002_8004, 32'h5555_5555, 4'hF);
        check("snoop_after_pop", 32'(pending_match), 32'd0);

        // Stray invalidate completion during a cache write is ignored
        push(32'h0000_0100, 32'h6666_6666, 4'h9, 1'b0, 1'b0);
        tick();
        cacheinv_done = 1'b1;
        tick();
        cacheinv_done = 1'b0;
        check("stray_idone_strobe", 32'({cachewr_do, avm_write, cacheinv_do}), 32'b100);
        check("stray_idone_empty", 32'(empty), 32'd0);
        wait_cache("E", 30'h0000_0040, 32'h6666_6666, 4'h9);

        // Reset while invalidating
        push(32'h0000_2040, 32'h7777_7777, 4'hF, 1'b0, 1'b1);
        wait_avm("R1", 30'h0000_0810, 32'h7777_7777, 4'hF);
        check("r1_in_inv", 32'(cacheinv_do), 32'd1);
        snoop_address = 30'h0000_0810;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_after_reset("rst_inv");

        // Reset while stalled in an uncached write
        avm_waitrequest = 1'b1;
        push(32'h0000_3000, 32'h8888_8888, 4'hF, 1'b1, 1'b0);
        tick();
        check("r2_in_uncached", 32'(avm_write), 32'd1);
        rst = 1'b1;
        tick();
        rst             = 1'b0;
        avm_waitrequest = 1'b0;
        snoop_address   = 30'h0000_0C00;
        #1;
        check_idle_after_reset("rst_unc");

        // Routing after reset
        push(32'h0000_4000, 32'h9999_9999, 4'h1, 1'b0, 1'b0);
        push(32'h0000_5010, 32'hAAAA_AAAA, 4'h2, 1'b0, 1'b1);
        wait_cache("F", 30'h0000_1000, 32'h9999_9999, 4'h1);
        wait_avm("G", 30'h0000_1404, 32'hAAAA_AAAA, 4'h2);
        wait_inv("G", 28'h000_0501);
        check("final_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
